// File: rtl/pc88_loader_sink.sv
// Loader responder: packs loader bytes into 16-bit SDRAM word writes via a pending word buffer.
// Latency: partial-word byte ACKs 3 cycles after LOADER_WR; word-completing byte ACKs 1 cycle after the cycle mem_ack is sampled.
// Backpressure: LOADER_ACK withheld while a mem write is outstanding; mem_req/addr/wdat/be held until mem_ack.
module pc88_loader_sink #(
    parameter int                ADDR_W = 22,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic              clk21m,
    input  logic              rstn,
    input  logic [18:0]       LOADER_ADR,
    input  logic [7:0]        LOADER_WDAT,
    input  logic              LOADER_OE,
    input  logic              LOADER_WR,
    output logic              LOADER_ACK,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdat,
    output logic [1:0]        mem_be,
    input  logic              mem_ack,
    output logic              load_busy,
    output logic              load_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DECIDE  = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_FLUSH_W = 3'd3;
    localparam logic [2:0] S_ACKH    = 3'd4;
    localparam logic [2:0] S_FLUSH_E = 3'd5;

    logic [2:0]        state;
    logic [18:0]       req_adr;
    logic [7:0]        req_dat;
    logic              pend_v;
    logic [ADDR_W-1:0] pend_wa;
    logic [15:0]       pend_d;
    logic [1:0]        pend_be;
    logic              oe_q;
    logic              eod;
    logic              ack_q;
    logic              req_q;
    logic              done_q;

    // Word address wraps at ADDR_W bits; no saturation.
    logic [ADDR_W-1:0] req_wa;
    logic [1:0]        lane_be;
    logic [1:0]        merged_be;
    logic [15:0]       merged_d;
    logic              oe_fall;
    logic              oe_rise;

    assign req_wa    = BASE + ADDR_W'(req_adr[18:1]);
    assign lane_be   = req_adr[0] ? 2'b10 : 2'b01;
    // pend_be/pend_d are zeroed whenever the buffer empties, so OR-merge is safe.
    assign merged_be = pend_be | lane_be;
    assign merged_d  = req_adr[0] ? {req_dat, pend_d[7:0]} : {pend_d[15:8], req_dat};
    assign oe_fall   = oe_q & ~LOADER_OE;
    assign oe_rise   = ~oe_q & LOADER_OE;

    assign LOADER_ACK = ack_q;
    assign mem_req    = req_q;
    assign mem_addr   = pend_wa;
    assign mem_wdat   = pend_d;
    assign mem_be     = pend_be;
    assign load_done  = done_q;
    assign load_busy  = (state != S_IDLE) | eod;

    // Delayed LOADER_OE for edge detection.
    always_ff @(posedge clk21m or negedge rstn) begin
        if (!rstn) oe_q <= 1'b0;
        else       oe_q <= LOADER_OE;
    end

    // Handshake FSM, pending word buffer and end-of-download bookkeeping.
    always_ff @(posedge clk21m or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            req_adr <= '0;
            req_dat <= '0;
            pend_v  <= 1'b0;
            pend_wa <= '0;
            pend_d  <= '0;
            pend_be <= '0;
            eod     <= 1'b0;
            ack_q   <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (eod) begin
                        if (pend_v) begin
                            req_q <= 1'b1;
                            state <= S_FLUSH_E;
                        end else begin
                            done_q <= 1'b1;
                            eod    <= 1'b0;
                        end
                    end else if (LOADER_WR && !ack_q && LOADER_OE) begin
                        req_adr <= LOADER_ADR;
                        req_dat <= LOADER_WDAT;
                        state   <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    if (pend_v && (pend_wa != req_wa)) begin
                        // Old word must go out first; the captured byte is re-decided afterwards.
                        req_q <= 1'b1;
                        state <= S_FLUSH_W;
                    end else begin
                        pend_v  <= 1'b1;
                        pend_wa <= req_wa;
                        pend_d  <= merged_d;
                        pend_be <= merged_be;
                        if (merged_be == 2'b11) begin
                            req_q <= 1'b1;
                            state <= S_WRITE;
                        end else begin
                            state <= S_ACKH;
                        end
                    end
                end
                S_WRITE, S_FLUSH_W, S_FLUSH_E: begin
                    if (mem_ack) begin
                        req_q   <= 1'b0;
                        pend_v  <= 1'b0;
                        pend_d  <= '0;
                        pend_be <= '0;
                        if (state == S_WRITE) begin
                            state <= S_ACKH;
                        end else if (state == S_FLUSH_W) begin
                            state <= S_DECIDE;
                        end else begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                            eod    <= 1'b0;
                        end
                    end
                end
                S_ACKH: begin
                    if (LOADER_WR) begin
                        ack_q <= 1'b1;
                    end else begin
                        ack_q <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // A falling OE is remembered even mid-transaction; restart clears done.
            if (oe_fall) eod <= 1'b1;
            if (oe_rise) done_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc88_loader_sink.sv
// Bench for pc88_loader_sink: directed scenarios plus a random byte stream.
// Expected SDRAM writes come from a run-grouping model over each download's byte list.
// A behavioural arbiter acknowledges requests after a programmable delay.
module tb_pc88_loader_sink;
    localparam logic [21:0] BASE = 22'h3FFFF0;

    logic        clk21m = 1'b0;
    logic        rstn;
    logic [18:0] LOADER_ADR;
    logic [7:0]  LOADER_WDAT;
    logic        LOADER_OE;
    logic        LOADER_WR;
    logic        LOADER_ACK;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic [15:0] mem_wdat;
    logic [1:0]  mem_be;
    logic        mem_ack;
    logic        load_busy;
    logic        load_done;

    pc88_loader_sink #(.ADDR_W(22), .BASE(BASE)) dut (
        .clk21m(clk21m), .rstn(rstn),
        .LOADER_ADR(LOADER_ADR), .LOADER_WDAT(LOADER_WDAT),
        .LOADER_OE(LOADER_OE), .LOADER_WR(LOADER_WR), .LOADER_ACK(LOADER_ACK),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_be(mem_be),
        .mem_ack(mem_ack), .load_busy(load_busy), .load_done(load_done)
    );

    initial forever #5 clk21m = ~clk21m;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk21m) cyc <= cyc + 1;

    logic [21:0] act_addr[$];
    logic [15:0] act_dat[$];
    logic [1:0]  act_be[$];
    logic [18:0] s_adr[$];
    logic [7:0]  s_dat[$];

    int ack_delay     = 1;
    int unstable      = 0;
    int ack_in_req    = 0;
    int ack_drive_cyc = 0;
    int ack_rises     = 0;
    int last_lat      = 0;
    int drop_lat      = 0;
    int ack_seen_cyc  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] word_of(input logic [18:0] a);
        int unsigned w;
        w = int'(BASE) + int'(a >> 1);
        return 22'(w & 32'h003F_FFFF);
    endfunction

    // Behavioural arbiter: acknowledge after ack_delay cycles, watch stability while waiting.
    initial begin : arbiter
        logic [21:0] a0;
        logic [15:0] d0;
        logic [1:0]  b0;
        logic        aborted;
        mem_ack = 1'b0;
        forever begin
            @(negedge clk21m);
            if (rstn === 1'b1 && mem_req === 1'b1) begin
                a0 = mem_addr; d0 = mem_wdat; b0 = mem_be; aborted = 1'b0;
                if (LOADER_ACK === 1'b1) ack_in_req++;
                for (int k = 0; k < ack_delay; k++) begin
                    @(negedge clk21m);
                    if (rstn !== 1'b1) begin aborted = 1'b1; break; end
                    if (mem_req !== 1'b1 || mem_addr !== a0 || mem_wdat !== d0 || mem_be !== b0) unstable++;
                    if (LOADER_ACK === 1'b1) ack_in_req++;
                end
                if (!aborted) begin
                    mem_ack = 1'b1;
                    ack_drive_cyc = cyc;
                    act_addr.push_back(a0); act_dat.push_back(d0); act_be.push_back(b0);
                    @(negedge clk21m);
                    mem_ack = 1'b0;
                end
            end
        end
    end

    // Count LOADER_ACK rising edges.
    initial begin : ack_mon
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk21m);
            if (LOADER_ACK === 1'b1 && prev === 1'b0) ack_rises++;
            prev = LOADER_ACK;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [18:0] adr, input logic [7:0] dat);
        int n;
        n = 0;
        while (LOADER_ACK !== 1'b0 && n < 200) begin @(negedge clk21m); n++; end
        LOADER_ADR = adr; LOADER_WDAT = dat; LOADER_WR = 1'b1;
        s_adr.push_back(adr); s_dat.push_back(dat);
        n = 0;
        do begin @(negedge clk21m); n++; end while (LOADER_ACK !== 1'b1 && n < 500);
        last_lat = n; ack_seen_cyc = cyc;
        check("byte_ack_up", LOADER_ACK, 1);
        LOADER_WR = 1'b0;
        n = 0;
        do begin @(negedge clk21m); n++; end while (LOADER_ACK !== 1'b0 && n < 50);
        drop_lat = n;
        check("byte_ack_down", LOADER_ACK, 0);
    endtask

    task automatic start_session();
        LOADER_OE = 1'b1;
        @(negedge clk21m);
        check("done_cleared_on_oe_rise", load_done, 0);
    endtask

    // Drop OE, wait for load_done, then compare all writes against the grouped byte list.
    task automatic end_session(input string name);
        int n;
        int i;
        logic [21:0] wa;
        logic [15:0] d;
        logic [1:0]  be;
        logic [21:0] e_addr[$];
        logic [15:0] e_dat[$];
        logic [1:0]  e_be[$];
        LOADER_OE = 1'b0;
        n = 0;
        do begin @(negedge clk21m); n++; end while (load_done !== 1'b1 && n < 400);
        check({name, "_load_done"}, load_done, 1);
        check({name, "_busy_idle"}, load_busy, 0);
        i = 0;
        while (i < s_adr.size()) begin
            wa = word_of(s_adr[i]); d = '0; be = '0;
            while (i < s_adr.size() && word_of(s_adr[i]) == wa && be != 2'b11) begin
                if (s_adr[i][0]) begin d[15:8] = s_dat[i]; be[1] = 1'b1; end
                else             begin d[7:0]  = s_dat[i]; be[0] = 1'b1; end
                i++;
            end
            e_addr.push_back(wa); e_dat.push_back(d); e_be.push_back(be);
        end
        check({name, "_write_count"}, act_addr.size(), e_addr.size());
        for (int k = 0; k < e_addr.size() && k < act_addr.size(); k++) begin
            check($sformatf("%s_wr%0d_addr", name, k), act_addr[k], e_addr[k]);
            check($sformatf("%s_wr%0d_wdat", name, k), act_dat[k], e_dat[k]);
            check($sformatf("%s_wr%0d_be", name, k), act_be[k], e_be[k]);
        end
        act_addr.delete(); act_dat.delete(); act_be.delete();
        s_adr.delete(); s_dat.delete();
    endtask

    initial begin : main
        int r0;
        int n;
        logic held_ok;
        logic [18:0] cur;
        int r;
        rstn = 1'b0; LOADER_OE = 1'b0; LOADER_WR = 1'b0; LOADER_ADR = '0; LOADER_WDAT = '0;
        repeat (3) @(negedge clk21m);
        check("reset_outputs", {LOADER_ACK, mem_req, mem_addr, mem_wdat, mem_be, load_busy, load_done}, 0);
        rstn = 1'b1;
        @(negedge clk21m);

        // Sequential bytes 0..3.
        ack_delay = 2;
        start_session();
        r0 = ack_rises;
        send_byte(19'd0, 8'h11);
        check("even_byte_ack_latency", last_lat, 3);
        check("ack_drop_latency", drop_lat, 1);
        send_byte(19'd1, 8'h22);
        send_byte(19'd2, 8'h33);
        send_byte(19'd3, 8'h44);
        check("seq_ack_rises", ack_rises - r0, 4);
        check("seq_writes_before_eod", act_addr.size(), 2);
        end_session("seq");

        // Odd tail flushed at end of download.
        start_session();
        send_byte(19'd0, 8'hAA);
        send_byte(19'd1, 8'hBB);
        send_byte(19'd2, 8'hCC);
        end_session("tail");

        // Non-consecutive jump forces a flush before the second ACK.
        start_session();
        send_byte(19'd4, 8'h5A);
        send_byte(19'd10, 8'hA5);
        check("jump_flush_before_ack", act_addr.size(), 1);
        end_session("jump");

        // Slow arbiter.
        start_session();
        ack_delay = 20; unstable = 0; ack_in_req = 0;
        send_byte(19'h20, 8'h01);
        send_byte(19'h21, 8'h02);
        check("slow_req_stable", unstable, 0);
        check("slow_ack_low_during_req", ack_in_req, 0);
        check("slow_ack_after_mem_ack", ack_seen_cyc - ack_drive_cyc, 2);
        end_session("slow");

        // Four-phase initiator behaviour.
        ack_delay = 1;
        start_session();
        LOADER_ADR = 19'h40; LOADER_WDAT = 8'h11; LOADER_WR = 1'b1;
        s_adr.push_back(19'h40); s_dat.push_back(8'h11);
        n = 0;
        do begin @(negedge clk21m); n++; end while (LOADER_ACK !== 1'b1 && n < 100);
        check("fp_ack_up", LOADER_ACK, 1);
        r0 = ack_rises; held_ok = 1'b1;
        repeat (10) begin
            @(negedge clk21m);
            if (LOADER_ACK !== 1'b1 || load_busy !== 1'b1) held_ok = 1'b0;
        end
        check("fp_ack_held", held_ok, 1);
        check("fp_no_recapture", ack_rises - r0, 0);
        LOADER_WR = 1'b0;
        @(negedge clk21m);
        check("fp_ack_drop", LOADER_ACK, 0);
        LOADER_WDAT = 8'h99; LOADER_WR = 1'b1;
        s_adr.push_back(19'h40); s_dat.push_back(8'h99);
        n = 0;
        do begin @(negedge clk21m); n++; end while (LOADER_ACK !== 1'b1 && n < 100);
        check("fp_reraise_latency", n, 3);
        LOADER_WR = 1'b0;
        n = 0;
        do begin @(negedge clk21m); n++; end while (LOADER_ACK !== 1'b0 && n < 50);
        send_byte(19'h41, 8'h33);
        end_session("fourphase");

        // Word address wraps at 22 bits.
        start_session();
        send_byte(19'h7FFFE, 8'hDE);
        send_byte(19'h7FFFF, 8'hAD);
        check("wrap_write_seen", act_addr.size(), 1);
        if (act_addr.size() > 0) check("wrap_addr", act_addr[0], 22'h03FFEF);
        end_session("wrap");

        // Random stream with random arbiter delays.
        start_session();
        cur = 19'h100; r0 = ack_rises;
        for (int b = 0; b < 48; b++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      cur = cur + 19'd1;
            else if (r > 7) cur = 19'h100 + 19'($urandom_range(0, 63));
            ack_delay = $urandom_range(0, 4);
            send_byte(cur, 8'($urandom));
        end
        check("rand_ack_rises", ack_rises - r0, 48);
        end_session("rand");

        // WR while OE is low is ignored.
        LOADER_ADR = 19'd0; LOADER_WDAT = 8'h55; LOADER_WR = 1'b1;
        held_ok = 1'b1;
        repeat (10) begin
            @(negedge clk21m);
            if (LOADER_ACK !== 1'b0 || load_busy !== 1'b0) held_ok = 1'b0;
        end
        LOADER_WR = 1'b0;
        check("wr_ignored_oe_low", held_ok, 1);
        check("wr_ignored_no_write", act_addr.size(), 0);

        // Reset while a write is outstanding.
        ack_delay = 30;
        start_session();
        send_byte(19'd0, 8'h10);
        LOADER_ADR = 19'd1; LOADER_WDAT = 8'h20; LOADER_WR = 1'b1;
        n = 0;
        do begin @(negedge clk21m); n++; end while (mem_req !== 1'b1 && n < 50);
        check("mid_reset_req_seen", mem_req, 1);
        #2 rstn = 1'b0;
        #1 check("mid_reset_outputs", {LOADER_ACK, mem_req, mem_addr, mem_wdat, mem_be, load_busy, load_done}, 0);
        LOADER_WR = 1'b0;
        s_adr.delete(); s_dat.delete();
        repeat (2) @(negedge clk21m);
        rstn = 1'b1;
        ack_delay = 1;
        @(negedge clk21m);
        check("mid_reset_no_write", act_addr.size(), 0);
        send_byte(19'd0, 8'h77);
        end_session("after_reset");

        check("all_req_stable", unstable, 0);
        check("all_ack_low_during_req", ack_in_req, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
